// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: load, logical/arithmetic shifts and rotates by a
// variable amount, plus an autonomous LSB-first serialiser with a START/BUSY/DONE handshake.
module shift_reg_univ #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               CLK,
    input  logic               CLEAR_N,
    input  logic               CLR,
    input  logic               EN,
    input  logic [2:0]         MODE,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [WIDTH-1:0]   P_IN,
    input  logic               S_IN_L,
    input  logic               S_IN_R,
    input  logic               START,
    output logic [WIDTH-1:0]   P_OUT,
    output logic               S_OUT_L,
    output logic               S_OUT_R,
    output logic               BUSY,
    output logic               DONE
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic {
        IDLE,
        SER
    } state_t;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SRL  = 3'b001,
        MODE_SLL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_SRA  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic               done_q, done_n;

    logic [WIDTH-1:0]   srl_res, sll_res, sra_res, ror_res, rol_res;
    int unsigned        rot_amt;

    // The fill masks make any amount >= WIDTH collapse to an all-fill word without extra compares.
    assign rot_amt = 32'(SHAMT) % WIDTH;
    assign srl_res = (data_q >> SHAMT) | (S_IN_R ? ~(ONES >> SHAMT) : '0);
    assign sra_res = (data_q >> SHAMT) | (data_q[WIDTH-1] ? ~(ONES >> SHAMT) : '0);
    assign sll_res = (data_q << SHAMT) | (S_IN_L ? ~(ONES << SHAMT) : '0);
    assign ror_res = (data_q >> rot_amt) | (data_q << (WIDTH - rot_amt));
    assign rol_res = (data_q << rot_amt) | (data_q >> (WIDTH - rot_amt));

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        data_n  = data_q;
        state_n = state_q;
        count_n = count_q;
        done_n  = 1'b0;
        if (CLR) begin
            data_n  = '0;
            state_n = IDLE;
            count_n = '0;
        end else if (EN) begin
            if (state_q == SER) begin
                data_n = {S_IN_R, data_q[WIDTH-1:1]};
                if (count_q == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    count_n = count_q - 1'b1;
                end
            end else if (START) begin
                data_n  = P_IN;
                count_n = CNT_W'(WIDTH - 1);
                state_n = SER;
            end else begin
                case (mode_t'(MODE))
                    MODE_SRL:  data_n = srl_res;
                    MODE_SLL:  data_n = sll_res;
                    MODE_LOAD: data_n = P_IN;
                    MODE_ROR:  data_n = ror_res;
                    MODE_ROL:  data_n = rol_res;
                    MODE_SRA:  data_n = sra_res;
                    MODE_HOLD, MODE_RSVD: data_n = data_q;
                    default:   data_n = data_q;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            data_q  <= '0;
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_n;
            state_q <= state_n;
            count_q <= count_n;
            done_q  <= done_n;
        end
    end

    assign P_OUT   = data_q;
    assign S_OUT_L = data_q[WIDTH-1];
    assign S_OUT_R = data_q[0];
    assign BUSY    = (state_q == SER);
    assign DONE    = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios followed by random traffic, all checked
// against an arithmetic reference model of the register.
module tb_shift_reg_univ;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          CLK = 1'b0;
    logic          CLEAR_N, CLR, EN, START, S_IN_L, S_IN_R;
    logic [2:0]    MODE;
    logic [SW-1:0] SHAMT;
    logic [W-1:0]  P_IN;
    logic [W-1:0]  P_OUT;
    logic          S_OUT_L, S_OUT_R, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    // Reference model: register value, serial bits still to send, and DONE pulse.
    int   m_p;
    int   m_left;
    logic m_done;

    shift_reg_univ #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .CLK(CLK), .CLEAR_N(CLEAR_N), .CLR(CLR), .EN(EN), .MODE(MODE), .SHAMT(SHAMT),
        .P_IN(P_IN), .S_IN_L(S_IN_L), .S_IN_R(S_IN_R), .START(START),
        .P_OUT(P_OUT), .S_OUT_L(S_OUT_L), .S_OUT_R(S_OUT_R), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int shr_fill(input int p, input int s, input int f);
        if (s >= W) return f ? (2**W - 1) : 0;
        return p / 2**s + (f ? (2**W - 2**(W - s)) : 0);
    endfunction

    function automatic int shl_fill(input int p, input int s, input int f);
        if (s >= W) return f ? (2**W - 1) : 0;
        return (p * 2**s) % 2**W + (f ? (2**s - 1) : 0);
    endfunction

    function automatic int rot_r(input int p, input int s);
        int r;
        r = s % W;
        return p / 2**r + (p % 2**r) * 2**(W - r);
    endfunction

    function automatic int rot_l(input int p, input int s);
        return rot_r(p, (W - s % W) % W);
    endfunction

    task automatic model_edge();
        int s;
        s = int'(SHAMT);
        m_done = 1'b0;
        if (CLR) begin
            m_p    = 0;
            m_left = 0;
        end else if (EN) begin
            if (m_left > 0) begin
                m_p    = m_p / 2 + int'(S_IN_R) * 2**(W - 1);
                m_left = m_left - 1;
                m_done = (m_left == 0);
            end else if (START) begin
                m_p    = int'(P_IN);
                m_left = W;
            end else begin
                case (MODE)
                    3'b001: m_p = shr_fill(m_p, s, int'(S_IN_R));
                    3'b010: m_p = shl_fill(m_p, s, int'(S_IN_L));
                    3'b011: m_p = int'(P_IN);
                    3'b100: m_p = rot_r(m_p, s);
                    3'b101: m_p = rot_l(m_p, s);
                    3'b110: m_p = shr_fill(m_p, s, m_p / 2**(W - 1));
                    default: m_p = m_p;
                endcase
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".p_out"}, 32'(P_OUT), 32'(m_p));
        check({tag, ".busy"}, 32'(BUSY), 32'(m_left > 0));
        check({tag, ".done"}, 32'(DONE), 32'(m_done));
        check({tag, ".s_out_l"}, 32'(S_OUT_L), 32'(m_p / 2**(W - 1)));
        check({tag, ".s_out_r"}, 32'(S_OUT_R), 32'(m_p % 2));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        CLR = 1'b0; EN = 1'b1; START = 1'b0; MODE = 3'b000;
        SHAMT = '0; S_IN_L = 1'b0; S_IN_R = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        MODE = 3'b011; P_IN = v;
        tick("load");
        MODE = 3'b000;
    endtask

    task automatic op(input string tag, input logic [2:0] mode, input int s,
                      input logic sl, input logic sr, input logic [W-1:0] exp);
        MODE = mode; SHAMT = SW'(s); S_IN_L = sl; S_IN_R = sr;
        tick(tag);
        check({tag, ".plan"}, 32'(P_OUT), 32'(exp));
        idle_inputs();
    endtask

    initial begin
        logic [W-1:0] pv;
        int bit_idx;

        idle_inputs();
        P_IN = '0;
        CLEAR_N = 1'b0;
        m_p = 0; m_left = 0; m_done = 1'b0;
        #12;
        check("reset.p_out", 32'(P_OUT), 32'h0);
        check("reset.busy", 32'(BUSY), 32'h0);
        check("reset.done", 32'(DONE), 32'h0);
        CLEAR_N = 1'b1;

        // Synchronous clear wins over a low enable.
        load(8'hA5);
        CLR = 1'b1; EN = 1'b0;
        tick("clr_no_en");
        check("clr_no_en.plan", 32'(P_OUT), 32'h00);
        idle_inputs();

        load(8'h96); op("srl3", 3'b001, 3, 1'b0, 1'b1, 8'hF2);
        load(8'h96); op("sll2", 3'b010, 2, 1'b0, 1'b0, 8'h58);
        load(8'h96); op("sra7", 3'b110, 7, 1'b0, 1'b0, 8'hFF);
        load(8'h96); op("srl0", 3'b001, 0, 1'b1, 1'b1, 8'h96);
        load(8'h96); op("rol0", 3'b101, 0, 1'b0, 1'b0, 8'h96);
        load(8'h81); op("ror1", 3'b100, 1, 1'b0, 1'b0, 8'hC0);
        load(8'h81); op("rol4", 3'b101, 4, 1'b0, 1'b0, 8'h18);
        load(8'h5A); op("rsvd", 3'b111, 5, 1'b1, 1'b1, 8'h5A);

        // Serialiser with START and MODE=load held high throughout.
        pv = 8'hB4;
        P_IN = pv; START = 1'b1; MODE = 3'b011; S_IN_R = 1'b0;
        tick("ser_start");
        P_IN = 8'h3C;
        for (int i = 0; i < W; i++) begin
            check("ser.busy_bit", 32'(BUSY), 32'h1);
            check("ser.bit", 32'(S_OUT_R), 32'(pv[i]));
            tick("ser_run");
        end
        START = 1'b0; MODE = 3'b000;
        check("ser.done", 32'(DONE), 32'h1);
        check("ser.busy_end", 32'(BUSY), 32'h0);
        check("ser.p_end", 32'(P_OUT), 32'h00);
        tick("ser_after");
        check("ser.done_pulse", 32'(DONE), 32'h0);

        // Stall: three disabled cycles stretch BUSY to eleven cycles.
        pv = 8'h6D;
        P_IN = pv; START = 1'b1;
        tick("stall_start");
        START = 1'b0;
        bit_idx = 0;
        for (int c = 0; c < W + 3; c++) begin
            EN = !(c >= 3 && c <= 5);
            check("stall.busy", 32'(BUSY), 32'h1);
            if (EN) begin
                check("stall.bit", 32'(S_OUT_R), 32'(pv[bit_idx]));
                bit_idx++;
            end
            tick("stall_run");
        end
        EN = 1'b1;
        check("stall.busy_end", 32'(BUSY), 32'h0);
        check("stall.done", 32'(DONE), 32'h1);

        // Abort by CLR while the fourth bit is on S_OUT_R.
        P_IN = 8'hC3; START = 1'b1;
        tick("abort_start");
        START = 1'b0;
        for (int i = 0; i < 3; i++) tick("abort_run");
        CLR = 1'b1;
        tick("abort_clr");
        check("abort.busy", 32'(BUSY), 32'h0);
        check("abort.p_out", 32'(P_OUT), 32'h00);
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("abort_idle");
            check("abort.no_done", 32'(DONE), 32'h0);
        end

        // Asynchronous reset in the middle of a serialisation.
        P_IN = 8'hE7; START = 1'b1;
        tick("areset_start");
        START = 1'b0;
        tick("areset_run");
        #2;
        CLEAR_N = 1'b0;
        #1;
        check("areset.p_out", 32'(P_OUT), 32'h00);
        check("areset.busy", 32'(BUSY), 32'h0);
        check("areset.done", 32'(DONE), 32'h0);
        m_p = 0; m_left = 0; m_done = 1'b0;
        #3;
        CLEAR_N = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            CLR    = ($urandom_range(0, 24) == 0);
            EN     = ($urandom_range(0, 4) != 0);
            START  = ($urandom_range(0, 9) == 0);
            MODE   = 3'($urandom);
            SHAMT  = SW'($urandom);
            P_IN   = W'($urandom);
            S_IN_L = 1'($urandom);
            S_IN_R = 1'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
